// File: rtl/rx_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rx_gen                                                     |
// | Description : Asynchronous serial receiver. Idle-high line, LSB first,   |
// |               5..9 data bits, optional odd/even parity, 1 or 2 stop      |
// |               bits, parity/framing error flags and break detection.      |
// | Option      : RX_GEN_MAJORITY_EN - 2-of-3 majority vote per bit taken    |
// |               over centre-1, centre and centre+1 samples.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rx_gen #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 19200,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 parity_en,
  input  logic                 odd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 busy,
  output logic                 data_strobe,
  output logic                 parity_error,
  output logic                 framing_error
);

  // Bit timing. CLOCKS_PER_BIT must be at least 4 so that half a bit minus
  // one (the start-bit sample point) is a positive count.
  localparam int CLOCKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
  localparam int TIMER_W        = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W          = $clog2(DATA_BITS + 1);

`ifdef RX_GEN_MAJORITY_EN
  // The vote needs the centre+1 sample, so every decision lands one cycle later.
  localparam int SAMPLE_DELAY = 1;
`else
  localparam int SAMPLE_DELAY = 0;
`endif

  localparam logic [TIMER_W-1:0] C_START_SAMPLE = TIMER_W'(HALF_BIT - 1 + SAMPLE_DELAY);
  localparam logic [TIMER_W-1:0] C_BIT_LAST     = TIMER_W'(CLOCKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] C_TAIL_LAST    = TIMER_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0]   C_DATA_LAST    = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]   C_STOP_LAST    = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_q;
  logic                 rx_prev_q;
  logic                 seen_high_q;
  logic                 par_en_q;
  logic                 odd_q;
  logic                 par_err_q;
  logic                 frame_err_q;
  logic                 tail_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 busy_q;
  logic                 strobe_q;
  logic                 parity_error_q;
  logic                 framing_error_q;

  logic                 sample_bit;
  logic                 start_edge;

  // Register the line once; the previous value gives the falling-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q      <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_q      <= rx_in;
      rx_prev_q <= rx_q;
    end
  end

`ifdef RX_GEN_MAJORITY_EN
  logic rx_prev2_q;

  // One more history stage so the oldest of the three votes is available.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev2_q <= 1'b0;
    end else begin
      rx_prev2_q <= rx_prev_q;
    end
  end

  // At the decision point rx_q is centre+1, rx_prev_q centre, rx_prev2_q centre-1.
  assign sample_bit = (rx_q & rx_prev_q) | (rx_q & rx_prev2_q) | (rx_prev_q & rx_prev2_q);
`else
  assign sample_bit = rx_q;
`endif

  // A start is only recognised on a genuine high-to-low transition after the
  // line has been seen idle at least once since reset.
  assign start_edge = seen_high_q & rx_prev_q & ~rx_q;

  // Receive state machine: bit timing, sampling, shifting and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      seen_high_q     <= 1'b0;
      par_en_q        <= 1'b0;
      odd_q           <= 1'b0;
      par_err_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      tail_q          <= 1'b0;
      dout_q          <= '0;
      busy_q          <= 1'b0;
      strobe_q        <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (rx_q) begin
        seen_high_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          idx_q   <= '0;
          if (start_edge) begin
            // Framing options are frozen for the whole character here.
            state_q     <= S_START;
            busy_q      <= 1'b1;
            par_en_q    <= parity_en;
            odd_q       <= odd;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tail_q      <= 1'b0;
          end
        end

        S_START: begin
          if (timer_q == C_START_SAMPLE) begin
            timer_q <= '0;
            if (sample_bit) begin
              // Line back high at mid start bit: treat as a glitch.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_DATA: begin
          if (timer_q == C_BIT_LAST) begin
            timer_q <= '0;
            shift_q <= {sample_bit, shift_q[DATA_BITS-1:1]};
            if (idx_q == C_DATA_LAST) begin
              idx_q   <= '0;
              state_q <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_PARITY: begin
          if (timer_q == C_BIT_LAST) begin
            timer_q   <= '0;
            par_err_q <= sample_bit != ((^shift_q) ^ odd_q);
            state_q   <= S_STOP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_STOP: begin
          if (tail_q) begin
            // Hold busy for the remaining half of the final stop bit.
            if (timer_q == C_TAIL_LAST) begin
              timer_q <= '0;
              tail_q  <= 1'b0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end else if (timer_q == C_BIT_LAST) begin
            timer_q <= '0;
            if (idx_q == C_STOP_LAST) begin
              idx_q           <= '0;
              dout_q          <= shift_q;
              parity_error_q  <= par_err_q;
              framing_error_q <= frame_err_q | ~sample_bit;
              strobe_q        <= 1'b1;
              if (sample_bit) begin
                tail_q <= 1'b1;
              end else begin
                state_q <= S_BREAK;
              end
            end else begin
              frame_err_q <= frame_err_q | ~sample_bit;
              idx_q       <= idx_q + 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_BREAK: begin
          // Line held low past the stop bit: wait for it to return idle.
          timer_q <= '0;
          if (rx_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          timer_q <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign dout          = dout_q;
  assign busy          = busy_q;
  assign data_strobe   = strobe_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rx_gen                                                  |
// | Description : Self-checking bench for rx_gen. Two receivers: 8N1-style   |
// |               with runtime parity, and 7-bit / 2-stop.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rx_gen;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 62500;
  localparam int CPB    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx1;
  logic       rx2;
  logic       par_en;
  logic       odd;
  logic [7:0] dout1;
  logic       busy1, strobe1, perr1, ferr1;
  logic [6:0] dout2;
  logic       busy2, strobe2, perr2, ferr2;

  int checks = 0;
  int errors = 0;

  // Entries are {9-bit zero-extended data, parity_error, framing_error}.
  logic [10:0] exp1[$];
  logic [10:0] exp2[$];
  logic [10:0] obs1[$];
  logic [10:0] obs2[$];

  rx_gen #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD_RATE    (BAUD),
    .DATA_BITS    (8),
    .STOP_BITS    (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx1),
    .parity_en    (par_en),
    .odd          (odd),
    .dout         (dout1),
    .busy         (busy1),
    .data_strobe  (strobe1),
    .parity_error (perr1),
    .framing_error(ferr1)
  );

  rx_gen #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD_RATE    (BAUD),
    .DATA_BITS    (7),
    .STOP_BITS    (2)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx2),
    .parity_en    (par_en),
    .odd          (odd),
    .dout         (dout2),
    .busy         (busy2),
    .data_strobe  (strobe2),
    .parity_error (perr2),
    .framing_error(ferr2)
  );

  always #5 clk = ~clk;

  // Capture every strobe away from the active edge.
  always @(negedge clk) begin
    if (strobe1) obs1.push_back({1'b0, dout1, perr1, ferr1});
    if (strobe2) obs2.push_back({2'b00, dout2, perr2, ferr2});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input int line, input logic v, input int cycles);
    if (line == 1) rx1 = v;
    else rx2 = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Start bit, data LSB first, optional parity bit; stop bits left to caller.
  task automatic tx_frame(input int line, input logic [8:0] data, input int nbits,
                          input logic has_par, input logic par_bit);
    drive_bit(line, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive_bit(line, data[i], CPB);
    if (has_par) drive_bit(line, par_bit, CPB);
  endtask

  task automatic test_reset();
    logic bad;
    rst = 1'b1; rx1 = 1'b0; rx2 = 1'b1; par_en = 1'b0; odd = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout1, busy1, strobe1, perr1, ferr1} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: dout=%h busy=%b strobe=%b perr=%b ferr=%b, expected all 0",
               dout1, busy1, strobe1, perr1, ferr1);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy1 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL low_after_reset_busy: busy went %b while line low, expected 0", bad);
    end
    drive_bit(1, 1'b1, 3 * CPB);
    checks++;
    if (busy1 !== 1'b0 || obs1.size() != 0) begin
      errors++;
      $display("FAIL low_after_reset_strobe: busy=%b strobes=%0d, expected busy 0 strobes 0",
               busy1, obs1.size());
    end
  endtask

  task automatic test_good_parity();
    logic [10:0] got, want;
    logic [7:0]  d;
    d = 8'hA5;
    par_en = 1'b1; odd = 1'b1;
    exp1.push_back({1'b0, d, 1'b0, 1'b0});
    fork
      tx_frame(1, {1'b0, d}, 8, 1'b1, (^d) ^ 1'b1);
      begin
        // Options flipped mid-character must not matter.
        repeat (3 * CPB) @(negedge clk);
        par_en = 1'b0; odd = 1'b0;
      end
    join
    drive_bit(1, 1'b1, CPB / 2);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL a5_busy_mid_stop: busy=%b, expected 1", busy1);
    end
    drive_bit(1, 1'b1, CPB / 2 + 2 * CPB);
    checks++;
    if (obs1.size() != 1) begin
      errors++;
      $display("FAIL a5_strobe_count: got %0d strobes, expected 1", obs1.size());
      obs1.delete(); exp1.delete();
    end else begin
      got = obs1.pop_front(); want = exp1.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL a5_frame: dout=%h perr=%b ferr=%b, expected dout=%h perr=%b ferr=%b",
                 got[10:2], got[1], got[0], want[10:2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_parity_error();
    logic [10:0] got, want;
    logic [7:0]  d;
    d = 8'h5A;
    par_en = 1'b1; odd = 1'b0;
    exp1.push_back({1'b0, d, 1'b1, 1'b0});
    tx_frame(1, {1'b0, d}, 8, 1'b1, ~(^d));
    drive_bit(1, 1'b1, 3 * CPB);
    checks++;
    if (obs1.size() != 1) begin
      errors++;
      $display("FAIL 5a_strobe_count: got %0d strobes, expected 1", obs1.size());
      obs1.delete(); exp1.delete();
    end else begin
      got = obs1.pop_front(); want = exp1.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL 5a_parity_frame: dout=%h perr=%b ferr=%b, expected dout=%h perr=%b ferr=%b",
                 got[10:2], got[1], got[0], want[10:2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_break();
    logic [10:0] got, want;
    par_en = 1'b0; odd = 1'b0;
    exp1.push_back({1'b0, 8'h00, 1'b0, 1'b1});
    tx_frame(1, 9'h000, 8, 1'b0, 1'b0);
    drive_bit(1, 1'b0, 3 * CPB);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL break_busy_low_line: busy=%b, expected 1", busy1);
    end
    drive_bit(1, 1'b1, 3);
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL break_busy_release: busy=%b, expected 0", busy1);
    end
    drive_bit(1, 1'b1, 2 * CPB);
    checks++;
    if (obs1.size() != 1) begin
      errors++;
      $display("FAIL break_strobe_count: got %0d strobes, expected 1", obs1.size());
      obs1.delete(); exp1.delete();
    end else begin
      got = obs1.pop_front(); want = exp1.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL break_frame: dout=%h perr=%b ferr=%b, expected dout=%h perr=%b ferr=%b",
                 got[10:2], got[1], got[0], want[10:2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_seven_two_stop();
    logic [10:0] got, want;
    par_en = 1'b0; odd = 1'b0;
    exp2.push_back({2'b00, 7'h7F, 1'b0, 1'b0});
    tx_frame(2, 9'h07F, 7, 1'b0, 1'b0);
    drive_bit(2, 1'b1, 2 * CPB);
    drive_bit(2, 1'b1, 2 * CPB);
    checks++;
    if (obs2.size() != 1) begin
      errors++;
      $display("FAIL 7f_strobe_count: got %0d strobes, expected 1", obs2.size());
      obs2.delete(); exp2.delete();
    end else begin
      got = obs2.pop_front(); want = exp2.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL 7f_frame: dout=%h perr=%b ferr=%b, expected dout=%h perr=%b ferr=%b",
                 got[10:2], got[1], got[0], want[10:2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_false_start();
    drive_bit(2, 1'b0, 4);
    checks++;
    if (busy2 !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_start: busy=%b, expected 1", busy2);
    end
    drive_bit(2, 1'b0, 1);
    drive_bit(2, 1'b1, 3 * CPB);
    checks++;
    if (busy2 !== 1'b0 || obs2.size() != 0) begin
      errors++;
      $display("FAIL glitch_false_start: busy=%b strobes=%0d, expected busy 0 strobes 0",
               busy2, obs2.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, want;
    par_en = 1'b0; odd = 1'b0;
    fork
      tx_frame(1, 9'h0FF, 8, 1'b0, 1'b0);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_busy_before: busy=%b, expected 1", busy1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy1 !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_busy_after: busy=%b, expected 0", busy1);
        end
      end
    join
    drive_bit(1, 1'b1, 3 * CPB);
    checks++;
    if (obs1.size() != 0 || dout1 !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_no_strobe: strobes=%0d dout=%h, expected 0 strobes dout 00",
               obs1.size(), dout1);
      obs1.delete();
    end
    exp1.push_back({1'b0, 8'h3C, 1'b0, 1'b0});
    tx_frame(1, 9'h03C, 8, 1'b0, 1'b0);
    drive_bit(1, 1'b1, 3 * CPB);
    checks++;
    if (obs1.size() != 1) begin
      errors++;
      $display("FAIL 3c_strobe_count: got %0d strobes, expected 1", obs1.size());
      obs1.delete(); exp1.delete();
    end else begin
      got = obs1.pop_front(); want = exp1.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL 3c_frame: dout=%h perr=%b ferr=%b, expected dout=%h perr=%b ferr=%b",
                 got[10:2], got[1], got[0], want[10:2], want[1], want[0]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_parity();
    test_parity_error();
    test_break();
    test_seven_two_stop();
    test_false_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
